uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter DATA_W, default 8, width of each requester's data word and of P_DATA.
REQ-003 Parameter TIMEOUT, default 16, number of cycles to wait for Busy to rise after launch; used only under the configuration macro.
REQ-004 Port list (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on rising edge.
- reset, in, 1, asynchronous active-low reset.
- req_valid, in, N_REQ, per-requester frame request, level, held until accepted.
- req_data, in, N_REQ*DATA_W, requester i data in bits [i*DATA_W +: DATA_W].
- req_par_en, in, N_REQ, per-requester parity enable.
- req_par_typ, in, N_REQ, per-requester parity type (0 even, 1 odd).
- req_ready, out, N_REQ, one-hot, one-cycle accept pulse.
- DATA_VALID, out, 1, one-cycle launch strobe to the UART transmitter.
- P_DATA, out, DATA_W, frame data to the UART transmitter.
- PAR_EN, out, 1, parity enable to the UART transmitter.
- PAR_TYP, out, 1, parity type to the UART transmitter.
- Busy, in, 1, transmitter busy flag.
- grant_id, out, clog2(N_REQ), index of the requester currently owning the transmitter.
- arb_busy, out, 1, high whenever the FSM is not IDLE.
- timeout_err, out, 1, one-cycle pulse on launch timeout.

Function
REQ-005 FSM states: IDLE, LAUNCH, WAIT_HI, WAIT_LO.
REQ-006 IDLE, any req_valid set, and Busy==0: select the winner round-robin, searching from last_grant+1 with wrap at N_REQ-1 -> 0.
- Latch the winner's data, par_en and par_typ into registers.
- Set grant_id to the winner.
- Pulse req_ready[winner] for that cycle.
- Next state LAUNCH.
REQ-007 IDLE with Busy==1: no grant is issued and req_ready stays 0, regardless of req_valid.
REQ-008 LAUNCH: DATA_VALID=1 for exactly this one cycle; next state WAIT_HI.
REQ-009 P_DATA, PAR_EN and PAR_TYP come from the latched registers and stay stable from LAUNCH until return to IDLE. Changes on req_* inputs after accept have no effect.
REQ-010 WAIT_HI: stay until Busy==1, then go to WAIT_LO.
REQ-011 WAIT_LO: stay until Busy==0, then go to IDLE and set last_grant=grant_id.
REQ-012 Minimum spacing between consecutive DATA_VALID pulses is the frame duration plus 2 cycles.
REQ-013 Every req_valid bit held continuously is granted within N_REQ frames (no starvation).
REQ-014 If only one requester is valid, it is granted back-to-back.
REQ-015 req_ready is never asserted in any state other than IDLE.
REQ-016 req_ready is never asserted for more than one requester in the same cycle.
REQ-017 Requests that arrive or drop during LAUNCH, WAIT_HI or WAIT_LO are sampled only at the next IDLE.

Reset
REQ-018 While reset is low, asynchronously:
- state=IDLE, last_grant=N_REQ-1, so requester 0 has first priority.
- req_ready=0, DATA_VALID=0, P_DATA=0, PAR_EN=0, PAR_TYP=0, grant_id=0, arb_busy=0, timeout_err=0.
REQ-019 Reset asserted mid-frame aborts the sequence immediately. No DATA_VALID is issued until a new grant after reset release.

Configuration
REQ-020 Macro UART_ARB_TIMEOUT_EN.
- Defined: a counter runs in WAIT_HI. If Busy is not seen high within TIMEOUT cycles after LAUNCH, the FSM pulses timeout_err for one cycle, returns to IDLE and advances last_grant to grant_id.
- Undefined: WAIT_HI waits indefinitely and timeout_err is tied 0.

Verification
REQ-021 Reset: hold reset low for 3 cycles with req_valid=4'b1111 -> all outputs 0 and no req_ready during reset.
REQ-022 Single request: req_valid=4'b0100, req_data[2]=8'hA5, par_en=1, par_typ=1 ->
- req_ready=4'b0100 and grant_id=2.
- Next cycle: DATA_VALID=1, P_DATA=8'hA5, PAR_EN=1, PAR_TYP=1.
- Outputs stay stable until Busy falls.
REQ-023 Round-robin: all four requesters held valid across 5 frames -> grant order 0,1,2,3,0.
REQ-024 External busy: Busy=1 while in IDLE with req_valid=4'b0001 -> no req_ready until Busy=0; grant follows in the first IDLE cycle with Busy=0.
REQ-025 Mid-frame reset: assert reset during WAIT_LO -> outputs 0 immediately; after release, requester 0 is granted first.
REQ-026 Timeout, UART_ARB_TIMEOUT_EN defined, TIMEOUT=16: Busy tied 0 -> timeout_err pulses once 16 cycles after LAUNCH; the next grant goes to the next requester.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one UART transmitter.
// Optional launch timeout is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  input  logic [N_REQ-1:0]           req_par_en,
  input  logic [N_REQ-1:0]           req_par_typ,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       DATA_VALID,
  output logic [DATA_W-1:0]          P_DATA,
  output logic                       PAR_EN,
  output logic                       PAR_TYP,
  input  logic                       Busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       arb_busy,
  output logic                       timeout_err
);

  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_HI, WAIT_LO} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     last_grant_q, last_grant_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                par_en_q, par_en_d;
  logic                par_typ_q, par_typ_d;

  logic                win_found;
  logic [ID_W-1:0]     win_idx;
  logic                accept;
  int                  cand;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  // Search starts just after the last owner so every held request wins within N_REQ frames
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(last_grant_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(cand);
      end
    end
  end

  // Qualified by reset so no accept pulse leaks out while reset is held low
  assign accept = (state_q == IDLE) && win_found && !Busy && reset;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    data_d       = data_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    timeout_err  = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          grant_id_d = win_idx;
          data_d     = req_data[win_idx*DATA_W +: DATA_W];
          par_en_d   = req_par_en[win_idx];
          par_typ_d  = req_par_typ[win_idx];
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = WAIT_HI;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT_HI: begin
        if (Busy) begin
          state_d = WAIT_LO;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Transmitter never picked up the frame; give the slot to the next requester
          timeout_err  = 1'b1;
          last_grant_d = grant_id_q;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      WAIT_LO: begin
        if (!Busy) begin
          last_grant_d = grant_id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(N_REQ - 1);
      grant_id_q   <= '0;
      data_q       <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      data_q       <= data_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign req_ready  = accept ? (N_REQ'(1) << win_idx) : '0;
  assign grant_id   = accept ? win_idx : grant_id_q;
  assign DATA_VALID = (state_q == LAUNCH);
  assign arb_busy   = (state_q != IDLE);
  assign P_DATA     = data_q;
  assign PAR_EN     = par_en_q;
  assign PAR_TYP    = par_typ_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters, 8-bit data).
// Define UART_ARB_TIMEOUT_EN for both files to exercise the launch timeout.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_par_en;
  logic [3:0]  req_par_typ;
  logic [3:0]  req_ready;
  logic        DATA_VALID;
  logic [7:0]  P_DATA;
  logic        PAR_EN;
  logic        PAR_TYP;
  logic        Busy;
  logic [1:0]  grant_id;
  logic        arb_busy;
  logic        timeout_err;

  int total;
  int bad;

  uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_par_en(req_par_en), .req_par_typ(req_par_typ), .req_ready(req_ready),
    .DATA_VALID(DATA_VALID), .P_DATA(P_DATA), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .Busy(Busy), .grant_id(grant_id), .arb_busy(arb_busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; req_valid = '0; Busy = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Called at the LAUNCH negedge; returns at the negedge where the arbiter is back in IDLE
  task automatic run_busy();
    @(negedge clk); Busy = 1'b1;
    @(negedge clk); Busy = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [19:0] got;
    reset = 1'b0; req_valid = 4'b1111; Busy = 1'b0;
    req_data = 32'hDEADBEEF; req_par_en = 4'hF; req_par_typ = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      got = {req_ready, DATA_VALID, P_DATA, PAR_EN, PAR_TYP, grant_id, arb_busy, timeout_err};
      total++;
      if (got !== 20'h0) begin
        bad++; $display("[TB] FAIL reset_outputs cycle=%0d got=%05h exp=00000", c, got);
      end
    end
    req_valid = '0;
    reset = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100; req_data = 32'h00A50000; req_par_en = 4'b0100; req_par_typ = 4'b0100;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("[TB] FAIL single_ready got=%b exp=0100", req_ready); end
    total++; if (grant_id !== 2'd2) begin bad++; $display("[TB] FAIL single_grant got=%0d exp=2", grant_id); end
    total++; if (DATA_VALID !== 1'b0) begin bad++; $display("[TB] FAIL single_dv_early got=%b exp=0", DATA_VALID); end
    @(negedge clk);
    req_valid = '0; req_data = '1; req_par_en = '0; req_par_typ = '0;
    #1;
    total++; if ({DATA_VALID, P_DATA, PAR_EN, PAR_TYP} !== {1'b1, 8'hA5, 1'b1, 1'b1}) begin
      bad++; $display("[TB] FAIL single_launch got dv=%b data=%h pe=%b pt=%b exp dv=1 data=a5 pe=1 pt=1", DATA_VALID, P_DATA, PAR_EN, PAR_TYP);
    end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL single_ready_launch got=%b exp=0000", req_ready); end
    @(negedge clk); #1;
    total++; if ({DATA_VALID, arb_busy, P_DATA} !== {1'b0, 1'b1, 8'hA5}) begin
      bad++; $display("[TB] FAIL single_wait_hi got dv=%b busy=%b data=%h exp dv=0 busy=1 data=a5", DATA_VALID, arb_busy, P_DATA);
    end
    Busy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      total++; if ({DATA_VALID, P_DATA, PAR_EN, PAR_TYP} !== {1'b0, 8'hA5, 1'b1, 1'b1}) begin
        bad++; $display("[TB] FAIL single_hold cycle=%0d got dv=%b data=%h pe=%b pt=%b exp dv=0 data=a5 pe=1 pt=1", c, DATA_VALID, P_DATA, PAR_EN, PAR_TYP);
      end
    end
    Busy = 1'b0;
    @(negedge clk); #1;
    total++; if (arb_busy !== 1'b0) begin bad++; $display("[TB] FAIL single_idle got=%b exp=0", arb_busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0] pe_v;
    logic [3:0] pt_v;
    int         order [5];
    int         e;
    order = '{0, 1, 2, 3, 0};
    pe_v = 4'b1010; pt_v = 4'b0110;
    do_reset();
    req_valid = 4'b1111; req_data = 32'h44332211; req_par_en = pe_v; req_par_typ = pt_v;
    for (int f = 0; f < 5; f++) begin
      e = order[f];
      #1;
      total++; if (req_ready !== 4'(1 << e) || grant_id !== 2'(e)) begin
        bad++; $display("[TB] FAIL rr_grant frame=%0d got ready=%b id=%0d exp id=%0d", f, req_ready, grant_id, e);
      end
      @(negedge clk); #1;
      total++; if ({DATA_VALID, P_DATA, PAR_EN, PAR_TYP} !== {1'b1, 8'((e + 1) * 17), pe_v[e], pt_v[e]}) begin
        bad++; $display("[TB] FAIL rr_launch frame=%0d got dv=%b data=%h pe=%b pt=%b exp data=%h", f, DATA_VALID, P_DATA, PAR_EN, PAR_TYP, 8'((e + 1) * 17));
      end
      run_busy();
    end
    req_valid = '0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_valid = 4'b0010; req_data = 32'h00005A00; req_par_en = '0; req_par_typ = '0;
    for (int f = 0; f < 2; f++) begin
      #1;
      total++; if (req_ready !== 4'b0010) begin bad++; $display("[TB] FAIL b2b_ready frame=%0d got=%b exp=0010", f, req_ready); end
      @(negedge clk); #1;
      total++; if (DATA_VALID !== 1'b1 || P_DATA !== 8'h5A) begin
        bad++; $display("[TB] FAIL b2b_launch frame=%0d got dv=%b data=%h exp dv=1 data=5a", f, DATA_VALID, P_DATA);
      end
      run_busy();
    end
    req_valid = '0;
  endtask

  task automatic test_ext_busy();
    do_reset();
    Busy = 1'b1; req_valid = 4'b0001; req_data = 32'h000000C3;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (req_ready !== 4'b0000 || arb_busy !== 1'b0) begin
        bad++; $display("[TB] FAIL busy_block cycle=%0d got ready=%b arb=%b exp ready=0000 arb=0", c, req_ready, arb_busy);
      end
      @(negedge clk);
    end
    Busy = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0001 || grant_id !== 2'd0) begin
      bad++; $display("[TB] FAIL busy_release got ready=%b id=%0d exp ready=0001 id=0", req_ready, grant_id);
    end
    @(negedge clk); #1;
    total++; if (DATA_VALID !== 1'b1 || P_DATA !== 8'hC3) begin
      bad++; $display("[TB] FAIL busy_launch got dv=%b data=%h exp dv=1 data=c3", DATA_VALID, P_DATA);
    end
    req_valid = '0;
    run_busy();
  endtask

  task automatic test_midframe_reset();
    do_reset();
    req_data = 32'h44332211; req_par_en = 4'b1111; req_par_typ = 4'b1111;
    req_valid = 4'b0100;
    @(negedge clk);
    run_busy();
    req_valid = 4'b1111;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("[TB] FAIL mid_pre_grant got=%b exp=1000", req_ready); end
    @(negedge clk);
    @(negedge clk); Busy = 1'b1;
    @(negedge clk); #1;
    total++; if (arb_busy !== 1'b1 || P_DATA !== 8'h44) begin
      bad++; $display("[TB] FAIL mid_wait_lo got arb=%b data=%h exp arb=1 data=44", arb_busy, P_DATA);
    end
    reset = 1'b0;
    #1;
    total++; if ({req_ready, DATA_VALID, P_DATA, PAR_EN, PAR_TYP, grant_id, arb_busy} !== 19'h0) begin
      bad++; $display("[TB] FAIL mid_reset_outputs got ready=%b dv=%b data=%h pe=%b pt=%b id=%0d arb=%b exp all 0", req_ready, DATA_VALID, P_DATA, PAR_EN, PAR_TYP, grant_id, arb_busy);
    end
    Busy = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0001 || grant_id !== 2'd0) begin
      bad++; $display("[TB] FAIL mid_first_grant got ready=%b id=%0d exp ready=0001 id=0", req_ready, grant_id);
    end
    @(negedge clk); #1;
    total++; if (DATA_VALID !== 1'b1 || P_DATA !== 8'h11) begin
      bad++; $display("[TB] FAIL mid_launch got dv=%b data=%h exp dv=1 data=11", DATA_VALID, P_DATA);
    end
    req_valid = '0;
    run_busy();
  endtask

  task automatic test_timeout();
    logic exp_err;
    int   n_wait;
`ifdef UART_ARB_TIMEOUT_EN
    n_wait = 16;
`else
    n_wait = 20;
`endif
    do_reset();
    req_valid = 4'b0011; req_data = 32'h0000BBAA; Busy = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("[TB] FAIL to_first_grant got=%b exp=0001", req_ready); end
    @(negedge clk);
    for (int i = 1; i <= n_wait; i++) begin
      @(negedge clk); #1;
`ifdef UART_ARB_TIMEOUT_EN
      exp_err = (i == 16);
`else
      exp_err = 1'b0;
`endif
      total++; if (timeout_err !== exp_err) begin
        bad++; $display("[TB] FAIL to_pulse cycle=%0d got=%b exp=%b", i, timeout_err, exp_err);
      end
    end
`ifndef UART_ARB_TIMEOUT_EN
    total++; if (arb_busy !== 1'b1) begin bad++; $display("[TB] FAIL to_stuck got arb=%b exp=1", arb_busy); end
    Busy = 1'b1;
    @(negedge clk); Busy = 1'b0;
`endif
    @(negedge clk); #1;
    total++; if (req_ready !== 4'b0010 || timeout_err !== 1'b0) begin
      bad++; $display("[TB] FAIL to_next_grant got ready=%b err=%b exp ready=0010 err=0", req_ready, timeout_err);
    end
    req_valid = '0;
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b0; req_valid = '0; req_data = '0; req_par_en = '0; req_par_typ = '0; Busy = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_ext_busy();
    test_midframe_reset();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
